// File: rtl/ext_adc_pkg.sv
// Shared types and default geometry for the external serial ADC interface.
package ext_adc_pkg;

    localparam int unsigned DefClkDiv   = 4;
    localparam int unsigned DefLeadBits = 3;
    localparam int unsigned DefAdcBits  = 10;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        SCK_LO = 3'd2,
        SCK_HI = 3'd3,
        DONE   = 3'd4,
        HOLD   = 3'd5
    } state_e;

endpackage

// File: rtl/ext_adc_phase_cnt.sv
// Phase timer: counts ClkDiv cycles after each load, saturating at the terminal count.
module ext_adc_phase_cnt
    import ext_adc_pkg::*;
#(
    parameter int unsigned ClkDiv = DefClkDiv
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    output logic tc_c
);

    localparam int unsigned CntW = $clog2(ClkDiv + 1);

    logic [CntW-1:0] cnt;

    assign tc_c = (cnt == CntW'(ClkDiv - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= '0;
        end else if (!tc_c) begin
            cnt <= cnt + CntW'(1);
        end
    end

endmodule

// File: rtl/ext_adc_serial_if.sv
// Frames one conversion on a serial ADC: CS/SCK generation, MSB-first capture, completion strobe.
module ext_adc_serial_if
    import ext_adc_pkg::*;
#(
    parameter int unsigned ClkDiv   = DefClkDiv,
    parameter int unsigned LeadBits = DefLeadBits,
    parameter int unsigned AdcBits  = DefAdcBits
) (
    input  logic               Clk_i,
    input  logic               Reset_i,
    input  logic               AdcDoConvert_i,
    output logic               AdcConvComplete_o,
    output logic [AdcBits-1:0] AdcValue_o,
    output logic               Busy_o,
    output logic               AdcCS_n_o,
    output logic               AdcSCK_o,
    input  logic               AdcSDO_i
);

    localparam int unsigned NBits = LeadBits + AdcBits;
    localparam int unsigned BitW  = $clog2(NBits + 1);

    state_e             state;
    state_e             state_next;
    logic               tc;
    logic               load;
    logic               armed;
    logic               start_c;
    logic               last_c;
    logic [BitW-1:0]    bit_cnt;
    logic [AdcBits-1:0] shreg;
    logic               cs_n_d;
    logic               sck_d;
    logic               busy_d;
    logic               done_d;

    assign start_c = (state == IDLE) && AdcDoConvert_i && armed;
    assign last_c  = (bit_cnt == BitW'(NBits - 1));
    // Every state change restarts the phase timer, so each timed state lasts ClkDiv cycles.
    assign load    = (state_next != state);

    ext_adc_phase_cnt #(
        .ClkDiv (ClkDiv)
    ) u_phase_cnt (
        .clk   (Clk_i),
        .reset (Reset_i),
        .load  (load),
        .tc_c  (tc)
    );

    always_ff @(posedge Clk_i) begin
        if (Reset_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_c) state_next = SETUP;
            SETUP:   if (tc) state_next = SCK_LO;
            SCK_LO:  if (tc) state_next = SCK_HI;
            SCK_HI:  if (tc) state_next = last_c ? DONE : SCK_LO;
            DONE:    state_next = HOLD;
            HOLD:    if (tc) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs decode the upcoming state so the registered pins line up with the state itself.
    always_comb begin
        cs_n_d = 1'b1;
        sck_d  = 1'b0;
        busy_d = 1'b0;
        done_d = 1'b0;
        case (state_next)
            SETUP, SCK_LO: cs_n_d = 1'b0;
            SCK_HI: begin
                cs_n_d = 1'b0;
                sck_d  = 1'b1;
            end
            DONE:    done_d = 1'b1;
            default: ;
        endcase
        busy_d = (state_next != IDLE);
    end

    always_ff @(posedge Clk_i) begin
        if (Reset_i) begin
            AdcCS_n_o         <= 1'b1;
            AdcSCK_o          <= 1'b0;
            Busy_o            <= 1'b0;
            AdcConvComplete_o <= 1'b0;
        end else begin
            AdcCS_n_o         <= cs_n_d;
            AdcSCK_o          <= sck_d;
            Busy_o            <= busy_d;
            AdcConvComplete_o <= done_d;
        end
    end

    // Armed re-arms on any low request cycle so a held request starts only one frame.
    always_ff @(posedge Clk_i) begin
        if (Reset_i) begin
            armed      <= 1'b1;
            bit_cnt    <= '0;
            shreg      <= '0;
            AdcValue_o <= '0;
        end else begin
            if (!AdcDoConvert_i) begin
                armed <= 1'b1;
            end else if (start_c) begin
                armed <= 1'b0;
            end

            if (state == IDLE) begin
                bit_cnt <= '0;
            end else if ((state == SCK_HI) && tc && !last_c) begin
                bit_cnt <= bit_cnt + BitW'(1);
            end

            // Sample on the edge where SCK rises; lead periods are dropped.
            if ((state == SCK_LO) && tc && (32'(bit_cnt) >= LeadBits)) begin
                shreg <= (shreg << 1) | AdcBits'(AdcSDO_i);
            end

            if (state_next == DONE) begin
                AdcValue_o <= shreg;
            end
        end
    end

endmodule

// File: tb/tb_ext_adc_serial_if.sv
// Directed bench: default-divider and ClkDiv=1 instances sharing one behavioural serial ADC model.
module tb_ext_adc_serial_if;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_a = 1'b0;
    logic       req_b = 1'b0;
    logic       sel = 1'b0;
    logic       sdo;
    logic [9:0] adc_word = 10'h000;
    logic [12:0] frame;

    logic       done_a, busy_a, cs_a, sck_a;
    logic [9:0] val_a;
    logic       done_b, busy_b, cs_b, sck_b;
    logic [9:0] val_b;

    logic       m_done, m_busy, m_cs, m_sck;
    logic [9:0] m_val;

    logic       sck_q = 1'b0;
    int         rises = 0;

    int total = 0;
    int bad = 0;
    int n = 0;
    logic cs_prev = 1'b1;
    int cs_falls[$];
    int strobe_n[$];
    int strobe_val[$];
    int strobe_rises[$];

    always #5 clk = ~clk;

    ext_adc_serial_if u_dut_a (
        .Clk_i             (clk),
        .Reset_i           (rst),
        .AdcDoConvert_i    (req_a),
        .AdcConvComplete_o (done_a),
        .AdcValue_o        (val_a),
        .Busy_o            (busy_a),
        .AdcCS_n_o         (cs_a),
        .AdcSCK_o          (sck_a),
        .AdcSDO_i          (sdo)
    );

    ext_adc_serial_if #(
        .ClkDiv (1)
    ) u_dut_b (
        .Clk_i             (clk),
        .Reset_i           (rst),
        .AdcDoConvert_i    (req_b),
        .AdcConvComplete_o (done_b),
        .AdcValue_o        (val_b),
        .Busy_o            (busy_b),
        .AdcCS_n_o         (cs_b),
        .AdcSCK_o          (sck_b),
        .AdcSDO_i          (sdo)
    );

    assign m_done = sel ? done_b : done_a;
    assign m_busy = sel ? busy_b : busy_a;
    assign m_cs   = sel ? cs_b   : cs_a;
    assign m_sck  = sel ? sck_b  : sck_a;
    assign m_val  = sel ? val_b  : val_a;

    // ADC model: three lead bits of 1 then the word MSB first, advancing after each SCK rise.
    assign frame = {3'b111, adc_word};
    assign sdo   = (rises < 13) ? frame[12 - rises] : 1'b0;

    always @(negedge clk) begin
        sck_q <= m_sck;
        if (m_cs) begin
            rises <= 0;
        end else if (m_sck && !sck_q) begin
            rises <= rises + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        n++;
        if (cs_prev && !m_cs) cs_falls.push_back(n);
        if (m_done) begin
            strobe_n.push_back(n);
            strobe_val.push_back(int'(m_val));
            strobe_rises.push_back(rises);
        end
        cs_prev = m_cs;
    endtask

    task automatic clear();
        n = 0;
        cs_falls.delete();
        strobe_n.delete();
        strobe_val.delete();
        strobe_rises.delete();
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        check("rst_cs_n", 32'(cs_a), 32'd1);
        check("rst_sck", 32'(sck_a), 32'd0);
        check("rst_strobe", 32'(done_a), 32'd0);
        check("rst_value", 32'(val_a), 32'd0);
        check("rst_busy", 32'(busy_a), 32'd0);
        check("rst_b_cs_n", 32'(cs_b), 32'd1);
        rst = 1'b0;
        tick();

        // Request held for 300 cycles: exactly one frame
        adc_word = 10'h2A5;
        clear();
        req_a = 1'b1;
        repeat (300) tick();
        check("held_starts", 32'(cs_falls.size()), 32'd1);
        check("held_cs_low_cycle", 32'(cs_falls[0]), 32'd1);
        check("held_strobes", 32'(strobe_n.size()), 32'd1);
        check("held_latency", 32'(strobe_n[0]), 32'd109);
        check("held_value", 32'(strobe_val[0]), 32'h2A5);
        check("held_sck_rises", 32'(strobe_rises[0]), 32'd13);
        check("held_value_kept", 32'(val_a), 32'h2A5);
        check("held_idle_busy", 32'(busy_a), 32'd0);

        // Low for one cycle, then a one-cycle pulse: second frame runs to completion
        req_a = 1'b0;
        tick();
        adc_word = 10'h155;
        clear();
        req_a = 1'b1;
        tick();
        req_a = 1'b0;
        check("pulse_cs_n", 32'(m_cs), 32'd0);
        check("pulse_busy", 32'(m_busy), 32'd1);
        repeat (150) tick();
        check("pulse_starts", 32'(cs_falls.size()), 32'd1);
        check("pulse_strobes", 32'(strobe_n.size()), 32'd1);
        check("pulse_latency", 32'(strobe_n[0]), 32'd109);
        check("pulse_value", 32'(strobe_val[0]), 32'h155);

        // Reset during SCK period 6 aborts the frame
        adc_word = 10'h0F0;
        clear();
        req_a = 1'b1;
        tick();
        req_a = 1'b0;
        repeat (53) tick();
        check("abort_rises_before", 32'(rises), 32'd6);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_cs_n", 32'(cs_a), 32'd1);
        check("abort_sck", 32'(sck_a), 32'd0);
        check("abort_busy", 32'(busy_a), 32'd0);
        check("abort_strobe", 32'(done_a), 32'd0);
        check("abort_value", 32'(val_a), 32'd0);
        repeat (150) tick();
        check("abort_no_strobe", 32'(strobe_n.size()), 32'd0);
        clear();
        req_a = 1'b1;
        tick();
        req_a = 1'b0;
        repeat (130) tick();
        check("after_abort_strobes", 32'(strobe_n.size()), 32'd1);
        check("after_abort_latency", 32'(strobe_n[0]), 32'd109);
        check("after_abort_value", 32'(strobe_val[0]), 32'h0F0);

        // Request raised during HOLD waits for IDLE: DONE + 4 HOLD + 1 IDLE with CS_n high
        adc_word = 10'h3C3;
        clear();
        req_a = 1'b1;
        tick();
        req_a = 1'b0;
        repeat (109) tick();
        req_a = 1'b1;
        repeat (200) tick();
        req_a = 1'b0;
        tick();
        check("hold_starts", 32'(cs_falls.size()), 32'd2);
        check("hold_first_strobe", 32'(strobe_n[0]), 32'd109);
        check("hold_restart_cycle", 32'(cs_falls[1]), 32'd115);
        check("hold_cs_high_run", 32'(cs_falls[1] - strobe_n[0]), 32'd6);
        check("hold_strobes", 32'(strobe_n.size()), 32'd2);
        check("hold_second_latency", 32'(strobe_n[1] - cs_falls[1]), 32'd108);
        check("hold_second_value", 32'(strobe_val[1]), 32'h3C3);

        // ClkDiv=1 instance: back-to-back 0x3FF then 0x000
        sel = 1'b1;
        cs_prev = 1'b1;
        repeat (3) tick();
        adc_word = 10'h3FF;
        clear();
        req_b = 1'b1;
        tick();
        req_b = 1'b0;
        repeat (27) tick();
        adc_word = 10'h000;
        req_b = 1'b1;
        repeat (60) tick();
        req_b = 1'b0;
        tick();
        check("div1_starts", 32'(cs_falls.size()), 32'd2);
        check("div1_strobes", 32'(strobe_n.size()), 32'd2);
        check("div1_latency_1", 32'(strobe_n[0]), 32'd28);
        check("div1_value_1", 32'(strobe_val[0]), 32'h3FF);
        check("div1_restart_cycle", 32'(cs_falls[1]), 32'd31);
        check("div1_latency_2", 32'(strobe_n[1] - cs_falls[1]), 32'd27);
        check("div1_value_2", 32'(strobe_val[1]), 32'h000);
        check("div1_sck_rises", 32'(strobe_rises[1]), 32'd13);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
